// File: rtl/ila_mon_pkg.sv
// Shared definitions for the ILA refinement monitor: FSM state encoding,
// default parameter values and the mismatch-index width helper.
package ila_mon_pkg;

    localparam int DEF_NUM_MAPS   = 30;
    localparam int DEF_CNT_W      = 8;
    localparam int DEF_MAX_CYCLES = 132;
    localparam int DEF_REARM      = 0;
    localparam int INSTR_W        = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_TOUT  = 3'd4
    } state_e;

    // A single mapping still needs a one-bit index port.
    function automatic int idx_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ila_mon_prio_enc.sv
// Lowest-set-bit priority encoder used to report the first failing
// state mapping.
module ila_mon_prio_enc #(
    parameter int W     = 30,
    parameter int IDX_W = 5
) (
    input  logic [W-1:0]     req_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the top so the lowest set bit is the final assignment.
    always_comb begin
        any_o = |req_i;
        idx_o = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ila_refinement_monitor.sv
// Tracks one ILA instruction against the RTL: start pulse, bounded cycle
// count, commit-time mapping compare with sticky mismatch/timeout reporting.
//
// state    | meaning
// ST_IDLE  | waiting for issue_i
// ST_START | one-cycle start pulse on start_o
// ST_RUN   | counting cycles until end_cond_i or the cycle bound
// ST_DONE  | check done; terminal, or one cycle then IDLE when re-armed
// ST_TOUT  | bound exceeded without commit; terminal until rst
module ila_refinement_monitor
    import ila_mon_pkg::*;
#(
    parameter int  NUM_MAPS   = DEF_NUM_MAPS,
    parameter int  CNT_W      = DEF_CNT_W,
    parameter int  MAX_CYCLES = DEF_MAX_CYCLES,
    parameter int  REARM      = DEF_REARM,
    localparam int IDX_W      = idx_width(NUM_MAPS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_i,
    input  logic                end_cond_i,
    input  logic [NUM_MAPS-1:0] map_eq_i,
    input  logic [NUM_MAPS-1:0] map_mask_i,
    output logic                start_o,
    output logic                started_o,
    output logic                ended_o,
    output logic                resetted_o,
    output logic [CNT_W-1:0]    cycle_cnt_o,
    output logic                check_valid_o,
    output logic                mismatch_o,
    output logic [IDX_W-1:0]    mismatch_idx_o,
    output logic                timeout_o,
    output logic [INSTR_W-1:0]  instr_cnt_o
);

    localparam logic [CNT_W-1:0]   MAX_C     = CNT_W'(MAX_CYCLES);
    localparam logic [INSTR_W-1:0] INSTR_MAX = {INSTR_W{1'b1}};
    localparam bit                 REARM_EN  = (REARM != 0);

    state_e               state_q, state_d;
    logic                 start_q, start_d;
    logic                 started_q, started_d;
    logic                 ended_q, ended_d;
    logic                 check_valid_q, check_valid_d;
    logic                 mismatch_q, mismatch_d;
    logic [IDX_W-1:0]     mismatch_idx_q, mismatch_idx_d;
    logic                 timeout_q, timeout_d;
    logic [CNT_W-1:0]     cycle_cnt_q, cycle_cnt_d;
    logic [INSTR_W-1:0]   instr_cnt_q, instr_cnt_d;
    logic                 resetted_q = 1'b0;

    logic                 iend;
    logic                 at_bound;
    logic                 rearm_clear;
    logic [NUM_MAPS-1:0]  fail_vec;
    logic                 fail_any;
    logic [IDX_W-1:0]     fail_idx;

    assign iend        = end_cond_i && (state_q == ST_RUN);
    assign at_bound    = (cycle_cnt_q == MAX_C);
    assign rearm_clear = REARM_EN && (state_q == ST_DONE);
    assign fail_vec    = ~map_eq_i & map_mask_i;

    ila_mon_prio_enc #(
        .W     (NUM_MAPS),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .req_i (fail_vec),
        .any_o (fail_any),
        .idx_o (fail_idx)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (issue_i) state_d = ST_START;
            ST_START: state_d = ST_RUN;
            // Commit takes priority over the cycle bound.
            ST_RUN: begin
                if (iend) begin
                    state_d = ST_DONE;
                end else if (at_bound) begin
                    state_d = ST_TOUT;
                end
            end
            ST_DONE:  if (REARM_EN) state_d = ST_IDLE;
            ST_TOUT:  state_d = ST_TOUT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start_d        = (state_q == ST_IDLE) && issue_i;
        started_d      = started_q || (state_q == ST_START);
        ended_d        = ended_q || iend;
        check_valid_d  = iend;
        timeout_d      = timeout_q || ((state_q == ST_RUN) && at_bound && !iend);
        mismatch_d     = mismatch_q;
        mismatch_idx_d = mismatch_idx_q;
        cycle_cnt_d    = cycle_cnt_q;
        instr_cnt_d    = instr_cnt_q;

        if (((state_q == ST_START) || (state_q == ST_RUN)) && (cycle_cnt_q < MAX_C)) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end

        if (iend) begin
            if (instr_cnt_q != INSTR_MAX) begin
                instr_cnt_d = instr_cnt_q + INSTR_W'(1);
            end
            // Only the first failing instruction is recorded.
            if (fail_any && !mismatch_q) begin
                mismatch_d     = 1'b1;
                mismatch_idx_d = fail_idx;
            end
        end

        if (rearm_clear) begin
            started_d   = 1'b0;
            ended_d     = 1'b0;
            cycle_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            start_q        <= 1'b0;
            started_q      <= 1'b0;
            ended_q        <= 1'b0;
            check_valid_q  <= 1'b0;
            mismatch_q     <= 1'b0;
            mismatch_idx_q <= '0;
            timeout_q      <= 1'b0;
            cycle_cnt_q    <= '0;
            instr_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            start_q        <= start_d;
            started_q      <= started_d;
            ended_q        <= ended_d;
            check_valid_q  <= check_valid_d;
            mismatch_q     <= mismatch_d;
            mismatch_idx_q <= mismatch_idx_d;
            timeout_q      <= timeout_d;
            cycle_cnt_q    <= cycle_cnt_d;
            instr_cnt_q    <= instr_cnt_d;
        end
    end

    // Records that a reset has ever been seen; deliberately outside rst.
    always_ff @(posedge clk) begin
        resetted_q <= resetted_q || rst;
    end

    assign start_o        = start_q;
    assign started_o      = started_q;
    assign ended_o        = ended_q;
    assign resetted_o     = resetted_q;
    assign cycle_cnt_o    = cycle_cnt_q;
    assign check_valid_o  = check_valid_q;
    assign mismatch_o     = mismatch_q;
    assign mismatch_idx_o = mismatch_idx_q;
    assign timeout_o      = timeout_q;
    assign instr_cnt_o    = instr_cnt_q;

endmodule

// File: tb/tb_ila_refinement_monitor.sv
// Directed bench: per-cycle vector table on the default configuration, plus
// hand sequences for timeout, end-at-bound and re-arm behaviour.
module tb_ila_refinement_monitor;

    localparam int NM = 30;
    localparam int IW = 5;
    localparam logic [NM-1:0] ALL = 30'h3FFF_FFFF;
    localparam logic [NM-1:0] EQ2 = 30'h3FFF_FBF7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, issue, endc;
    logic [NM-1:0] eq, mask;

    logic        a_start, a_started, a_ended, a_rst, a_cv, a_mm, a_to;
    logic [7:0]  a_cnt;
    logic [IW-1:0] a_idx;
    logic [15:0] a_instr;

    logic        b_start, b_started, b_ended, b_rst, b_cv, b_mm, b_to;
    logic [7:0]  b_cnt;
    logic [IW-1:0] b_idx;
    logic [15:0] b_instr;

    logic        c_start, c_started, c_ended, c_rst, c_cv, c_mm, c_to;
    logic [7:0]  c_cnt;
    logic [IW-1:0] c_idx;
    logic [15:0] c_instr;

    ila_refinement_monitor dut_a (
        .clk(clk), .rst(rst), .issue_i(issue), .end_cond_i(endc),
        .map_eq_i(eq), .map_mask_i(mask),
        .start_o(a_start), .started_o(a_started), .ended_o(a_ended),
        .resetted_o(a_rst), .cycle_cnt_o(a_cnt), .check_valid_o(a_cv),
        .mismatch_o(a_mm), .mismatch_idx_o(a_idx), .timeout_o(a_to),
        .instr_cnt_o(a_instr));

    ila_refinement_monitor #(.MAX_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst), .issue_i(issue), .end_cond_i(endc),
        .map_eq_i(eq), .map_mask_i(mask),
        .start_o(b_start), .started_o(b_started), .ended_o(b_ended),
        .resetted_o(b_rst), .cycle_cnt_o(b_cnt), .check_valid_o(b_cv),
        .mismatch_o(b_mm), .mismatch_idx_o(b_idx), .timeout_o(b_to),
        .instr_cnt_o(b_instr));

    ila_refinement_monitor #(.REARM(1)) dut_c (
        .clk(clk), .rst(rst), .issue_i(issue), .end_cond_i(endc),
        .map_eq_i(eq), .map_mask_i(mask),
        .start_o(c_start), .started_o(c_started), .ended_o(c_ended),
        .resetted_o(c_rst), .cycle_cnt_o(c_cnt), .check_valid_o(c_cv),
        .mismatch_o(c_mm), .mismatch_idx_o(c_idx), .timeout_o(c_to),
        .instr_cnt_o(c_instr));

    typedef struct {
        bit            chk;
        logic          rst, issue, endc;
        logic [NM-1:0] eq, mask;
        logic          start, started, ended, cv, mm;
        logic [IW-1:0] idx;
        logic [7:0]    cnt;
        logic [15:0]   instr;
    } vec_t;

    vec_t vecs[28];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(bit c, logic r, logic is, logic en,
                                logic [NM-1:0] e, logic [NM-1:0] m,
                                logic st, logic sd, logic ed, logic v, logic mmx,
                                logic [IW-1:0] ix, logic [7:0] cn, logic [15:0] ic);
        vec_t t;
        t.chk = c; t.rst = r; t.issue = is; t.endc = en; t.eq = e; t.mask = m;
        t.start = st; t.started = sd; t.ended = ed; t.cv = v; t.mm = mmx;
        t.idx = ix; t.cnt = cn; t.instr = ic;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; issue = 1'b0; endc = 1'b0; eq = ALL; mask = ALL;

        // scenario 1: clean instruction
        vecs[0]  = mk(0,1,0,0,ALL,ALL, 0,0,0,0,0,0,0,0);
        vecs[1]  = mk(1,0,1,0,ALL,ALL, 0,0,0,0,0,0,0,0);
        vecs[2]  = mk(1,0,0,0,ALL,ALL, 1,0,0,0,0,0,0,0);
        vecs[3]  = mk(1,0,0,0,ALL,ALL, 0,1,0,0,0,0,1,0);
        vecs[4]  = mk(1,0,0,0,ALL,ALL, 0,1,0,0,0,0,2,0);
        vecs[5]  = mk(1,0,0,1,ALL,ALL, 0,1,0,0,0,0,3,0);
        vecs[6]  = mk(1,0,0,0,ALL,ALL, 0,1,1,1,0,0,4,1);
        vecs[7]  = mk(1,0,0,0,ALL,ALL, 0,1,1,0,0,0,4,1);
        // scenario 2: mappings 3 and 10 fail
        vecs[8]  = mk(1,1,0,0,EQ2,ALL, 0,1,1,0,0,0,4,1);
        vecs[9]  = mk(1,0,1,0,EQ2,ALL, 0,0,0,0,0,0,0,0);
        vecs[10] = mk(1,0,0,0,EQ2,ALL, 1,0,0,0,0,0,0,0);
        vecs[11] = mk(1,0,0,0,EQ2,ALL, 0,1,0,0,0,0,1,0);
        vecs[12] = mk(1,0,0,0,EQ2,ALL, 0,1,0,0,0,0,2,0);
        vecs[13] = mk(1,0,0,1,EQ2,ALL, 0,1,0,0,0,0,3,0);
        vecs[14] = mk(1,0,0,0,EQ2,ALL, 0,1,1,1,1,3,4,1);
        vecs[15] = mk(1,0,0,0,EQ2,ALL, 0,1,1,0,1,3,4,1);
        // zero mask passes; end_cond in IDLE/START ignored
        vecs[16] = mk(1,1,0,0,'0,'0, 0,1,1,0,1,3,4,1);
        vecs[17] = mk(1,0,1,1,'0,'0, 0,0,0,0,0,0,0,0);
        vecs[18] = mk(1,0,0,1,'0,'0, 1,0,0,0,0,0,0,0);
        vecs[19] = mk(1,0,0,1,'0,'0, 0,1,0,0,0,0,1,0);
        vecs[20] = mk(1,0,0,0,'0,'0, 0,1,1,1,0,0,2,1);
        // scenario 5: rst mid-RUN overrides issue/end
        vecs[21] = mk(1,1,0,0,ALL,ALL, 0,1,1,0,0,0,2,1);
        vecs[22] = mk(1,0,1,0,ALL,ALL, 0,0,0,0,0,0,0,0);
        vecs[23] = mk(1,0,0,0,ALL,ALL, 1,0,0,0,0,0,0,0);
        vecs[24] = mk(1,0,0,0,ALL,ALL, 0,1,0,0,0,0,1,0);
        vecs[25] = mk(1,1,1,1,ALL,ALL, 0,1,0,0,0,0,2,0);
        vecs[26] = mk(1,0,0,1,ALL,ALL, 0,0,0,0,0,0,0,0);
        vecs[27] = mk(1,0,0,0,ALL,ALL, 0,0,0,0,0,0,0,0);

        nxt();
        for (int i = 0; i < 28; i++) begin
            rst = vecs[i].rst; issue = vecs[i].issue; endc = vecs[i].endc;
            eq = vecs[i].eq; mask = vecs[i].mask;
            if (vecs[i].chk) begin
                chk($sformatf("row%0d_start", i),   a_start,   vecs[i].start);
                chk($sformatf("row%0d_started", i), a_started, vecs[i].started);
                chk($sformatf("row%0d_ended", i),   a_ended,   vecs[i].ended);
                chk($sformatf("row%0d_cv", i),      a_cv,      vecs[i].cv);
                chk($sformatf("row%0d_mm", i),      a_mm,      vecs[i].mm);
                chk($sformatf("row%0d_idx", i),     a_idx,     vecs[i].idx);
                chk($sformatf("row%0d_cnt", i),     a_cnt,     vecs[i].cnt);
                chk($sformatf("row%0d_instr", i),   a_instr,   vecs[i].instr);
                chk($sformatf("row%0d_to", i),      a_to,      1'b0);
                chk($sformatf("row%0d_resetted", i), a_rst,    1'b1);
            end
            nxt();
        end

        // scenario 3: MAX_CYCLES=4, no commit -> timeout
        rst = 1'b1; issue = 1'b0; endc = 1'b0; eq = ALL; mask = ALL;
        nxt();
        rst = 1'b0; issue = 1'b1;
        nxt();
        issue = 1'b0;
        chk("s3_start", b_start, 1'b1);
        nxt();
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("s3_cnt%0d", k), b_cnt, 8'(k));
            chk($sformatf("s3_to_at%0d", k), b_to, 1'b0);
            nxt();
        end
        endc = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("s3_to_%0d", k), b_to, 1'b1);
            chk($sformatf("s3_cnt_sat%0d", k), b_cnt, 8'd4);
            chk($sformatf("s3_cv_%0d", k), b_cv, 1'b0);
            chk($sformatf("s3_instr_%0d", k), b_instr, 16'd0);
            nxt();
        end
        endc = 1'b0;

        // scenario 6: commit in the same cycle the bound is reached
        rst = 1'b1;
        nxt();
        rst = 1'b0; issue = 1'b1;
        nxt();
        issue = 1'b0;
        nxt(); nxt(); nxt(); nxt();
        chk("s6_cnt_bound", b_cnt, 8'd4);
        endc = 1'b1;
        nxt();
        endc = 1'b0;
        chk("s6_cv", b_cv, 1'b1);
        chk("s6_ended", b_ended, 1'b1);
        chk("s6_to", b_to, 1'b0);
        chk("s6_instr", b_instr, 16'd1);
        nxt();
        chk("s6_to_after", b_to, 1'b0);
        chk("s6_cv_after", b_cv, 1'b0);

        // scenario 4: REARM=1, three instructions, issue in DONE ignored
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            issue = 1'b1;
            nxt();
            issue = 1'b0;
            chk($sformatf("s4_start%0d", n), c_start, 1'b1);
            nxt();
            endc = 1'b1;
            nxt();
            endc = 1'b0; issue = 1'b1;
            chk($sformatf("s4_cv%0d", n), c_cv, 1'b1);
            chk($sformatf("s4_ended%0d", n), c_ended, 1'b1);
            chk($sformatf("s4_instr%0d", n), c_instr, 16'(n + 1));
            nxt();
            issue = 1'b0;
            chk($sformatf("s4_idle_cnt%0d", n), c_cnt, 8'd0);
            chk($sformatf("s4_idle_started%0d", n), c_started, 1'b0);
            chk($sformatf("s4_idle_ended%0d", n), c_ended, 1'b0);
            chk($sformatf("s4_idle_start%0d", n), c_start, 1'b0);
            nxt();
            chk($sformatf("s4_no_restart%0d", n), c_start, 1'b0);
        end
        chk("s4_instr_final", c_instr, 16'd3);
        chk("s4_to", c_to, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
